// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO and one-at-a-time issue sequencer for the ALU.
// Optional push-time command screening is enabled by defining ALU_ISSUE_ERRCHK_EN.
module alu_issue_stage #(
    parameter int INPUT    = 8,
    parameter int DEPTH    = 4,
    parameter int BASE_LAT = 2,
    parameter int MUL_LAT  = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [INPUT-1:0]         IN_OPA,
    input  logic [INPUT-1:0]         IN_OPB,
    input  logic                     IN_CIN,
    input  logic [3:0]               IN_CMD,
    input  logic                     IN_MODE,
    input  logic [1:0]               IN_VLD,
    output logic [INPUT-1:0]         OPA,
    output logic [INPUT-1:0]         OPB,
    output logic                     CIN,
    output logic                     MODE,
    output logic [3:0]               CMD,
    output logic [1:0]               VALID,
    output logic                     CE,
    output logic                     RES_STROBE,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     ILLEGAL
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXL = (MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT;
    localparam int LW   = $clog2(MAXL + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct packed {
        logic [INPUT-1:0] opa;
        logic [INPUT-1:0] opb;
        logic             cin;
        logic [3:0]       cmd;
        logic             mode;
        logic [1:0]       vld;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        in_e;
    entry_t        head;
    entry_t        held;
    entry_t        out_e;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [LW-1:0] lat_cnt;
    logic [LW-1:0] lat_m1;
    logic [CW-1:0] count_nxt;
    logic          push_fire;
    logic          accept;
    logic          pop;
    logic          is_mul;
    logic          legal;

    assign in_e      = '{IN_OPA, IN_OPB, IN_CIN, IN_CMD, IN_MODE, IN_VLD};
    assign head      = mem[rd_ptr];
    assign IN_READY  = (COUNT != CW'(DEPTH));
    assign push_fire = IN_VALID && IN_READY;
    assign accept    = push_fire && legal;
    assign pop       = (state == S_DONE);
    assign count_nxt = COUNT + CW'(accept) - CW'(pop);

    assign is_mul = head.mode && (head.cmd == 4'd9 || head.cmd == 4'd10);
    assign lat_m1 = is_mul ? LW'(MUL_LAT - 1) : LW'(BASE_LAT - 1);

`ifdef ALU_ISSUE_ERRCHK_EN
    function automatic logic cmd_legal(input logic m, input logic [1:0] v,
                                       input logic [3:0] c);
        logic ok;
        ok = 1'b0;
        case ({m, v})
            3'b111: ok = (c <= 4'd3) || (c >= 4'd8 && c <= 4'd12);
            3'b101: ok = (c == 4'd4) || (c == 4'd5);
            3'b110: ok = (c == 4'd6) || (c == 4'd7);
            3'b011: ok = (c <= 4'd5) || (c == 4'd12) || (c == 4'd13);
            3'b001: ok = (c == 4'd6) || (c == 4'd8) || (c == 4'd9);
            3'b010: ok = (c == 4'd7) || (c == 4'd10) || (c == 4'd11);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign legal = cmd_legal(IN_MODE, IN_VLD, IN_CMD);

    // Flag a dropped command the cycle after its handshake
    always_ff @(posedge CLK) begin
        if (RST) ILLEGAL <= 1'b0;
        else     ILLEGAL <= push_fire && !legal;
    end
`else
    assign legal   = 1'b1;
    assign ILLEGAL = 1'b0;
`endif

    // Operands come straight from the head during ISSUE, then from the held copy
    assign out_e      = (state == S_ISSUE) ? head : held;
    assign OPA        = out_e.opa;
    assign OPB        = out_e.opb;
    assign CIN        = out_e.cin;
    assign MODE       = out_e.mode;
    assign CMD        = out_e.cmd;
    assign VALID      = out_e.vld;
    assign CE         = (state != S_IDLE);
    assign BUSY       = (state != S_IDLE);
    assign RES_STROBE = (state == S_DONE);

    // Sequencer next-state: one command in flight, issue follows done directly
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (COUNT != '0) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (lat_m1 == '0) ? S_DONE : S_WAIT;
            S_WAIT:  if (lat_cnt == LW'(1)) state_nxt = S_DONE;
            default: state_nxt = (count_nxt != '0) ? S_ISSUE : S_IDLE;
        endcase
    end

    // FIFO storage write; contents need no reset, a blocked write suffices
    always_ff @(posedge CLK) begin
        if (accept && !RST) mem[wr_ptr] <= in_e;
    end

    // Pointers, occupancy, state, latency counter and held operands
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            COUNT   <= '0;
            state   <= S_IDLE;
            lat_cnt <= '0;
            held    <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            COUNT <= count_nxt;
            state <= state_nxt;
            if (state == S_ISSUE) begin
                lat_cnt <= lat_m1;
                held    <= head;
            end else if (state == S_WAIT) begin
                lat_cnt <= lat_cnt - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed checks of the ALU command issue stage.
// Define ALU_ISSUE_ERRCHK_EN for both bench and RTL to check command screening.
module tb_alu_issue_stage;

    logic       CLK = 1'b0;
    logic       RST;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] IN_OPA, IN_OPB;
    logic       IN_CIN;
    logic [3:0] IN_CMD;
    logic       IN_MODE;
    logic [1:0] IN_VLD;
    logic [7:0] OPA, OPB;
    logic       CIN, MODE;
    logic [3:0] CMD;
    logic [1:0] VALID;
    logic       CE, RES_STROBE, BUSY, ILLEGAL;
    logic [2:0] COUNT;

    int tests = 0;
    int fails = 0;

    logic       log_en = 1'b0;
    logic [7:0] log_q[$];

    alu_issue_stage dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_OPA(IN_OPA), .IN_OPB(IN_OPB), .IN_CIN(IN_CIN),
        .IN_CMD(IN_CMD), .IN_MODE(IN_MODE), .IN_VLD(IN_VLD),
        .OPA(OPA), .OPB(OPB), .CIN(CIN), .MODE(MODE),
        .CMD(CMD), .VALID(VALID), .CE(CE),
        .RES_STROBE(RES_STROBE), .BUSY(BUSY),
        .COUNT(COUNT), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    // Record the operand A of every completed command
    always @(negedge CLK) begin
        if (log_en && RES_STROBE) log_q.push_back(OPA);
    end

    task automatic idle_inputs();
        IN_VALID = 1'b0;
        IN_OPA = '0; IN_OPB = '0; IN_CIN = 1'b0;
        IN_CMD = '0; IN_MODE = 1'b0; IN_VLD = '0;
    endtask

    task automatic set_cmd(input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] c, input logic m,
                           input logic [1:0] v);
        IN_VALID = 1'b1;
        IN_OPA = a; IN_OPB = b; IN_CIN = 1'b0;
        IN_CMD = c; IN_MODE = m; IN_VLD = v;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        log_q.delete();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((BUSY || COUNT != 0) && g < 60) begin
            @(negedge CLK);
            g++;
        end
        @(negedge CLK);
        tests++;
        if (g >= 60) begin
            fails++;
            $display("FAIL drain_timeout: busy=%0b count=%0d required idle", BUSY, COUNT);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        tests++;
        if ({CE, RES_STROBE, BUSY, ILLEGAL} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: ce/strobe/busy/ill=%b required 0000",
                     {CE, RES_STROBE, BUSY, ILLEGAL});
        end
        tests++;
        if (COUNT !== 3'd0 || IN_READY !== 1'b1) begin
            fails++;
            $display("FAIL reset_fifo: count=%0d ready=%b required 0/1", COUNT, IN_READY);
        end
        tests++;
        if ({OPA, OPB, CIN, MODE, CMD, VALID} !== 24'h0) begin
            fails++;
            $display("FAIL reset_alu_out: got %h required 0",
                     {OPA, OPB, CIN, MODE, CMD, VALID});
        end
        RST = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_cmd(8'h05, 8'h03, 4'd0, 1'b1, 2'b11);
        @(negedge CLK);
        idle_inputs();
        tests++;
        if (COUNT !== 3'd1 || CE !== 1'b0) begin
            fails++;
            $display("FAIL single_push: count=%0d ce=%b required 1/0", COUNT, CE);
        end
        @(negedge CLK);
        tests++;
        if ({CE, RES_STROBE, OPA, OPB} !== {2'b10, 8'h05, 8'h03}) begin
            fails++;
            $display("FAIL single_issue: ce,strobe,opa,opb=%h required %h",
                     {CE, RES_STROBE, OPA, OPB}, {2'b10, 8'h05, 8'h03});
        end
        @(negedge CLK);
        tests++;
        if ({CE, RES_STROBE, OPA, OPB} !== {2'b10, 8'h05, 8'h03}) begin
            fails++;
            $display("FAIL single_wait: ce,strobe,opa,opb=%h required %h",
                     {CE, RES_STROBE, OPA, OPB}, {2'b10, 8'h05, 8'h03});
        end
        @(negedge CLK);
        tests++;
        if ({CE, RES_STROBE, OPA, OPB} !== {2'b11, 8'h05, 8'h03}) begin
            fails++;
            $display("FAIL single_done: ce,strobe,opa,opb=%h required %h",
                     {CE, RES_STROBE, OPA, OPB}, {2'b11, 8'h05, 8'h03});
        end
        @(negedge CLK);
        tests++;
        if ({CE, RES_STROBE, BUSY, COUNT, OPA} !== {3'b000, 3'd0, 8'h05}) begin
            fails++;
            $display("FAIL single_idle_hold: ce,strobe,busy,count,opa=%h required %h",
                     {CE, RES_STROBE, BUSY, COUNT, OPA}, {3'b000, 3'd0, 8'h05});
        end
    endtask

    task automatic test_mul_back_to_back();
        logic [6:0] st, ce;
        logic [7:0] oa0, oa4;
        logic [3:0] cmd0, cmd4;
        do_reset();
        set_cmd(8'h07, 8'h06, 4'd9, 1'b1, 2'b11);
        @(negedge CLK);
        set_cmd(8'h01, 8'h02, 4'd0, 1'b1, 2'b11);
        @(negedge CLK);
        idle_inputs();
        oa0 = '0; oa4 = '0; cmd0 = '0; cmd4 = '0;
        for (int i = 0; i < 7; i++) begin
            st[i] = RES_STROBE;
            ce[i] = CE;
            if (i == 0) begin oa0 = OPA; cmd0 = CMD; end
            if (i == 4) begin oa4 = OPA; cmd4 = CMD; end
            @(negedge CLK);
        end
        tests++;
        if (st !== 7'b1001000) begin
            fails++;
            $display("FAIL b2b_strobe_pattern: got %b required 1001000", st);
        end
        tests++;
        if (ce !== 7'b1111111) begin
            fails++;
            $display("FAIL b2b_ce_pattern: got %b required 1111111", ce);
        end
        tests++;
        if ({oa0, cmd0, oa4, cmd4} !== {8'h07, 4'd9, 8'h01, 4'd0}) begin
            fails++;
            $display("FAIL b2b_issue_operands: got %h required %h",
                     {oa0, cmd0, oa4, cmd4}, {8'h07, 4'd9, 8'h01, 4'd0});
        end
        tests++;
        if (CE !== 1'b0 || COUNT !== 3'd0) begin
            fails++;
            $display("FAIL b2b_end_idle: ce=%b count=%0d required 0/0", CE, COUNT);
        end
    endtask

    task automatic test_full();
        int acc[5];
        int cyc, g;
        logic r, saw_full;
        do_reset();
        log_en = 1'b1;
        cyc = 0;
        saw_full = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_cmd(8'h10 + 8'(k), 8'h20, 4'd1, 1'b0, 2'b11);
            g = 0;
            do begin
                r = IN_READY;
                if (COUNT == 3'd4 && !IN_READY) saw_full = 1'b1;
                @(negedge CLK);
                cyc++;
                g++;
            end while (!r && g < 20);
            acc[k] = cyc - 1;
        end
        idle_inputs();
        drain();
        log_en = 1'b0;
        tests++;
        if (saw_full !== 1'b1) begin
            fails++;
            $display("FAIL full_ready_low: saw_full=%b required 1", saw_full);
        end
        tests++;
        if (acc[3] != 3 || acc[4] != 5) begin
            fails++;
            $display("FAIL full_accept_edges: 4th=%0d 5th=%0d required 3/5", acc[3], acc[4]);
        end
        tests++;
        if (log_q.size() != 5) begin
            fails++;
            $display("FAIL full_strobe_count: got %0d required 5", log_q.size());
        end
        for (int k = 0; k < 5 && k < log_q.size(); k++) begin
            tests++;
            if (log_q[k] !== 8'h10 + 8'(k)) begin
                fails++;
                $display("FAIL full_order[%0d]: opa=%h required %h", k, log_q[k], 8'h10 + 8'(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_cmd(8'h40 + 8'(k), 8'h01, 4'd0, 1'b1, 2'b11);
            @(negedge CLK);
        end
        idle_inputs();
        @(negedge CLK);
        @(negedge CLK);
        tests++;
        if ({COUNT, CE, RES_STROBE} !== {3'd3, 2'b10}) begin
            fails++;
            $display("FAIL rstmid_pre: count=%0d ce=%b strobe=%b required 3/1/0",
                     COUNT, CE, RES_STROBE);
        end
        RST = 1'b1;
        set_cmd(8'h55, 8'h55, 4'd0, 1'b1, 2'b11);
        @(negedge CLK);
        RST = 1'b0;
        idle_inputs();
        tests++;
        if ({COUNT, CE, RES_STROBE, IN_READY, BUSY} !== {3'd0, 4'b0010}) begin
            fails++;
            $display("FAIL rstmid_flush: count=%0d ce=%b strobe=%b ready=%b busy=%b required 0/0/0/1/0",
                     COUNT, CE, RES_STROBE, IN_READY, BUSY);
        end
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (CE || RES_STROBE || COUNT != 0) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_quiet: activity=%b required 0", bad);
        end
    endtask

    task automatic test_illegal();
        logic bad;
        do_reset();
        set_cmd(8'h09, 8'h09, 4'd0, 1'b0, 2'b01);
        @(negedge CLK);
        idle_inputs();
`ifdef ALU_ISSUE_ERRCHK_EN
        tests++;
        if (ILLEGAL !== 1'b1 || COUNT !== 3'd0) begin
            fails++;
            $display("FAIL illegal_pulse: ill=%b count=%0d required 1/0", ILLEGAL, COUNT);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (CE || ILLEGAL || COUNT != 0) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL illegal_dropped: activity=%b required 0", bad);
        end
        set_cmd(8'h0A, 8'h0B, 4'd6, 1'b0, 2'b01);
        @(negedge CLK);
        idle_inputs();
        tests++;
        if (ILLEGAL !== 1'b0 || COUNT !== 3'd1) begin
            fails++;
            $display("FAIL legal_after_illegal: ill=%b count=%0d required 0/1", ILLEGAL, COUNT);
        end
        drain();
`else
        tests++;
        if (ILLEGAL !== 1'b0 || COUNT !== 3'd1) begin
            fails++;
            $display("FAIL unscreened_push: ill=%b count=%0d required 0/1", ILLEGAL, COUNT);
        end
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (ILLEGAL) bad = 1'b1;
            if (RES_STROBE !== (i == 2)) bad = 1'b1;
        end
        tests++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL unscreened_issue: deviation=%b required 0", bad);
        end
        drain();
`endif
    endtask

    task automatic test_simul_push_pop();
        do_reset();
        log_en = 1'b1;
        set_cmd(8'h31, 8'h00, 4'd2, 1'b1, 2'b11);
        @(negedge CLK);
        set_cmd(8'h32, 8'h00, 4'd2, 1'b1, 2'b11);
        @(negedge CLK);
        idle_inputs();
        @(negedge CLK);
        @(negedge CLK);
        tests++;
        if (RES_STROBE !== 1'b1 || COUNT !== 3'd2) begin
            fails++;
            $display("FAIL simul_pre: strobe=%b count=%0d required 1/2", RES_STROBE, COUNT);
        end
        set_cmd(8'h33, 8'h00, 4'd2, 1'b1, 2'b11);
        @(negedge CLK);
        idle_inputs();
        tests++;
        if ({COUNT, CE, RES_STROBE, OPA} !== {3'd2, 2'b10, 8'h32}) begin
            fails++;
            $display("FAIL simul_count: count,ce,strobe,opa=%h required %h",
                     {COUNT, CE, RES_STROBE, OPA}, {3'd2, 2'b10, 8'h32});
        end
        drain();
        log_en = 1'b0;
        tests++;
        if (log_q.size() != 3 || log_q[0] !== 8'h31 || log_q[1] !== 8'h32 || log_q[2] !== 8'h33) begin
            fails++;
            $display("FAIL simul_order: n=%0d required 3 in order 31,32,33", log_q.size());
        end
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_mul_back_to_back();
        test_full();
        test_reset_mid();
        test_illegal();
        test_simul_push_pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
